// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply, restoring divide, sign fix in a final cycle.
// Define MULDIV_DIV_EN to build the divider and accept codes 0x0E-0x11; otherwise only multiplies are supported.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic [4:0]      arith_control_i,
    input  logic [XLEN-1:0] operand_a_i,
    input  logic [XLEN-1:0] operand_b_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o,
    output logic            illegal_o
);

    localparam int CW = $clog2(XLEN + 1);

    localparam logic [4:0] OP_MUL    = 5'h0A;
    localparam logic [4:0] OP_MULH   = 5'h0B;
    localparam logic [4:0] OP_MULHSU = 5'h0C;
    localparam logic [4:0] OP_MULHU  = 5'h0D;
`ifdef MULDIV_DIV_EN
    localparam logic [4:0] OP_DIV    = 5'h0E;
    localparam logic [4:0] OP_DIVU   = 5'h0F;
    localparam logic [4:0] OP_REM    = 5'h10;
    localparam logic [4:0] OP_REMU   = 5'h11;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic [XLEN-1:0] mcand_q, mcand_d;
    logic            neg_q, neg_d;
    logic            hi_sel_q, hi_sel_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            illegal_q, illegal_d;

    logic            op_ok, op_hi, a_sgn, b_sgn, sa, sb, neg_start;
    logic [XLEN-1:0] abs_a, abs_b;

    logic [XLEN:0]     mul_sum;
    logic [XLEN-1:0]   mul_hi_nx, mul_lo_nx;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   mul_res, fix_res;

`ifdef MULDIV_DIV_EN
    logic            op_div, op_rem, b_zero;
    logic            div_q, div_d, rem_sel_q, rem_sel_d;
    logic [XLEN:0]   div_shift, div_trial;
    logic            div_qbit;
    logic [XLEN-1:0] div_hi_nx, div_lo_nx, div_raw, div_res;
`endif

    // Operation decode: support, result half, and operand signedness.
    always_comb begin
        op_ok = 1'b0;
        op_hi = 1'b0;
        a_sgn = 1'b0;
        b_sgn = 1'b0;
`ifdef MULDIV_DIV_EN
        op_div = 1'b0;
        op_rem = 1'b0;
`endif
        case (arith_control_i)
            OP_MUL:    begin op_ok = 1'b1; a_sgn = 1'b1; b_sgn = 1'b1; end
            OP_MULH:   begin op_ok = 1'b1; op_hi = 1'b1; a_sgn = 1'b1; b_sgn = 1'b1; end
            OP_MULHSU: begin op_ok = 1'b1; op_hi = 1'b1; a_sgn = 1'b1; end
            OP_MULHU:  begin op_ok = 1'b1; op_hi = 1'b1; end
`ifdef MULDIV_DIV_EN
            OP_DIV:    begin op_ok = 1'b1; op_div = 1'b1; a_sgn = 1'b1; b_sgn = 1'b1; end
            OP_DIVU:   begin op_ok = 1'b1; op_div = 1'b1; end
            OP_REM:    begin op_ok = 1'b1; op_div = 1'b1; op_rem = 1'b1; a_sgn = 1'b1; b_sgn = 1'b1; end
            OP_REMU:   begin op_ok = 1'b1; op_div = 1'b1; op_rem = 1'b1; end
`endif
            default:   op_ok = 1'b0;
        endcase

        sa        = a_sgn & operand_a_i[XLEN-1];
        sb        = b_sgn & operand_b_i[XLEN-1];
        abs_a     = sa ? -operand_a_i : operand_a_i;
        abs_b     = sb ? -operand_b_i : operand_b_i;
        neg_start = sa ^ sb;
`ifdef MULDIV_DIV_EN
        // Divide-by-zero must yield all ones, so the quotient is never negated then.
        b_zero = (operand_b_i == '0);
        if (op_rem)
            neg_start = sa;
        else if (op_div)
            neg_start = (sa ^ sb) & ~b_zero;
`endif
    end

    // Datapath steps and final sign correction.
    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
        mul_hi_nx = mul_sum[XLEN:1];
        mul_lo_nx = {mul_sum[0], lo_q[XLEN-1:1]};

        prod_fix = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
        mul_res  = hi_sel_q ? prod_fix[2*XLEN-1:XLEN] : prod_fix[XLEN-1:0];
        fix_res  = mul_res;

`ifdef MULDIV_DIV_EN
        // A set top bit means the partial remainder already exceeds any divisor.
        div_shift = {hi_q, lo_q[XLEN-1]};
        div_trial = div_shift - {1'b0, mcand_q};
        div_qbit  = div_shift[XLEN] | ~div_trial[XLEN];
        div_hi_nx = div_qbit ? div_trial[XLEN-1:0] : div_shift[XLEN-1:0];
        div_lo_nx = {lo_q[XLEN-2:0], div_qbit};

        div_raw = rem_sel_q ? hi_q : lo_q;
        div_res = neg_q ? -div_raw : div_raw;
        if (div_q)
            fix_res = div_res;
`endif
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        mcand_d   = mcand_q;
        neg_d     = neg_q;
        hi_sel_d  = hi_sel_q;
        result_d  = result_q;
        illegal_d = 1'b0;
        done_o    = 1'b0;
`ifdef MULDIV_DIV_EN
        div_d     = div_q;
        rem_sel_d = rem_sel_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start_i && !flush_i) begin
                    if (op_ok) begin
                        state_d  = S_CALC;
                        cnt_d    = CW'(XLEN);
                        hi_d     = '0;
                        lo_d     = abs_a;
                        mcand_d  = abs_b;
                        neg_d    = neg_start;
                        hi_sel_d = op_hi;
`ifdef MULDIV_DIV_EN
                        div_d     = op_div;
                        rem_sel_d = op_rem;
`endif
                    end else begin
                        illegal_d = 1'b1;
                    end
                end
            end
            S_CALC: begin
                if (flush_i) begin
                    state_d = S_IDLE;
                end else begin
`ifdef MULDIV_DIV_EN
                    if (div_q) begin
                        hi_d = div_hi_nx;
                        lo_d = div_lo_nx;
                    end else
`endif
                    begin
                        hi_d = mul_hi_nx;
                        lo_d = mul_lo_nx;
                    end
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1))
                        state_d = S_FIX;
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                if (!flush_i) begin
                    done_o   = 1'b1;
                    result_d = fix_res;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy_o    = (state_q != S_IDLE);
    // The corrected value is visible in the done cycle itself; result_q holds it afterwards.
    assign result_o  = done_o ? fix_res : result_q;
    assign illegal_o = illegal_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            mcand_q   <= '0;
            neg_q     <= 1'b0;
            hi_sel_q  <= 1'b0;
            result_q  <= '0;
            illegal_q <= 1'b0;
`ifdef MULDIV_DIV_EN
            div_q     <= 1'b0;
            rem_sel_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            mcand_q   <= mcand_d;
            neg_q     <= neg_d;
            hi_sel_q  <= hi_sel_d;
            result_q  <= result_d;
            illegal_q <= illegal_d;
`ifdef MULDIV_DIV_EN
            div_q     <= div_d;
            rem_sel_q <= rem_sel_d;
`endif
        end
    end

endmodule
